// File: rtl/delay_arbiter_pkg.sv
// Shared encodings for the delay arbiter: unit selects, FSM states, defaults
// and the time-base strobe mux.
package delay_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 10;

    typedef enum logic [1:0] {
        UNIT_US  = 2'd0,
        UNIT_MS  = 2'd1,
        UNIT_S   = 2'd2,
        UNIT_CLK = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Raw-cycle unit counts every clock, so its strobe is constant 1.
    function automatic logic sel_tick(input unit_e unit, input logic t_us,
                                      input logic t_ms, input logic t_s);
        case (unit)
            UNIT_US: return t_us;
            UNIT_MS: return t_ms;
            UNIT_S:  return t_s;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/delay_arbiter_if.sv
// Requester-side bundle of the delay arbiter: per-requester request, unit and
// count in; grant, done pulse and debug status out.
interface delay_arbiter_if
    import delay_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
);
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0][1:0]            req_unit;
    logic [NUM_REQ-1:0][CNT_W-1:0]      req_cnt;
    logic [NUM_REQ-1:0]                 gnt;
    logic [NUM_REQ-1:0]                 done;
    logic                               busy;
    logic [CNT_W-1:0]                   remaining;

    modport master (output req, req_unit, req_cnt,
                    input  gnt, done, busy, remaining);
    modport slave  (input  req, req_unit, req_cnt,
                    output gnt, done, busy, remaining);
endinterface

// File: rtl/delay_arbiter_rr_arbiter.sv
// Round-robin picker: combinational one-hot winner searched upward from ptr,
// ptr advances past the winner whenever a grant is taken.
module rr_arbiter
    import delay_arb_pkg::*;
#(
    parameter int  NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk_main,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_gnt_en,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        o_pick  = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
        o_pick[o_idx] = o_valid;
    end

    always_ff @(posedge clk_main) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (i_gnt_en && o_valid)
            r_ptr <= (o_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
    end

endmodule

// File: rtl/delay_arbiter.sv
// Shared programmable countdown timer: one owner at a time counts us/ms/s
// strobes or raw clocks, then gets a one-cycle done pulse.
module delay_arbiter
    import delay_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic          clk_main,
    input  logic          rst_n,
    input  logic          i_tick_1us,
    input  logic          i_tick_1ms,
    input  logic          i_tick_1s,
    delay_arbiter_if.slave arb_bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               r_state;
    unit_e                r_unit;
    logic [CNT_W-1:0]     r_remaining;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_busy;
    logic [IDX_W-1:0]     r_owner;

    logic [NUM_REQ-1:0]   w_pick;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_valid;
    logic                 w_gnt_en;
    logic                 w_strobe;
    logic                 w_cancel;

    assign w_gnt_en = (r_state == ST_IDLE);
    assign w_strobe = sel_tick(r_unit, i_tick_1us, i_tick_1ms, i_tick_1s);
    assign w_cancel = !arb_bus.req[r_owner];

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk_main (clk_main),
        .rst_n    (rst_n),
        .i_req    (arb_bus.req),
        .i_gnt_en (w_gnt_en),
        .o_pick   (w_pick),
        .o_idx    (w_idx),
        .o_valid  (w_valid)
    );

    always_ff @(posedge clk_main) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_unit      <= UNIT_US;
            r_remaining <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_busy      <= 1'b0;
            r_owner     <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_unit      <= unit_e'(arb_bus.req_unit[w_idx]);
                        r_remaining <= arb_bus.req_cnt[w_idx];
                        r_gnt       <= w_pick;
                        r_owner     <= w_idx;
                        r_busy      <= 1'b1;
                        // Zero count skips RUN; done rides with the grant.
                        if (arb_bus.req_cnt[w_idx] == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= w_pick;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Cancel outranks a tick landing in the same cycle.
                    if (w_cancel) begin
                        r_state     <= ST_IDLE;
                        r_gnt       <= '0;
                        r_remaining <= '0;
                        r_busy      <= 1'b0;
                    end else if (w_strobe) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= ST_DONE;
                            r_done  <= r_gnt;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign arb_bus.gnt       = r_gnt;
    assign arb_bus.done      = r_done;
    assign arb_bus.busy      = r_busy;
    assign arb_bus.remaining = r_remaining;

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter: stimulus pushes expected grant/done events,
// a negedge monitor pops and compares them; spot checks cover debug outputs.
module tb_delay_arbiter;
    import delay_arb_pkg::*;

    localparam int NR = 4;
    localparam int CW = 10;

    logic clk_main = 1'b0;
    logic rst_n    = 1'b0;
    logic t_us     = 1'b0;
    logic t_ms     = 1'b0;
    logic t_s      = 1'b0;

    delay_arbiter_if #(.NUM_REQ(NR), .CNT_W(CW)) bus ();

    delay_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk_main   (clk_main),
        .rst_n      (rst_n),
        .i_tick_1us (t_us),
        .i_tick_1ms (t_ms),
        .i_tick_1s  (t_s),
        .arb_bus    (bus)
    );

    always #5 clk_main = ~clk_main;

    int cyc = 0;
    always @(posedge clk_main) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 = grant rising edge, 1 = done pulse
        int mask;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic push(input int kind, input int idx, input int c);
        ev_t e;
        e.kind = kind;
        e.mask = 1 << idx;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic mon_check(input int kind, input logic [NR-1:0] mask);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d mask %0h at cycle %0d, none expected",
                     kind, mask, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.mask != int'(mask) || e.cyc != cyc) begin
                errors++;
                $display("FAIL event: got kind %0d mask %0h cycle %0d, expected kind %0d mask %0h cycle %0d",
                         kind, mask, cyc, e.kind, e.mask, e.cyc);
            end
        end
    endtask

    logic [NR-1:0] prev_gnt = '0;
    logic [NR-1:0] rise;
    always @(negedge clk_main) begin
        rise     = bus.gnt & ~prev_gnt;
        prev_gnt = bus.gnt;
        if (rise != '0)     mon_check(0, rise);
        if (bus.done != '0) mon_check(1, bus.done);
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_main);
            #1;
        end
    endtask

    task automatic set_req(input int i, input int unit, input int cnt);
        bus.req_unit[i] = 2'(unit);
        bus.req_cnt[i]  = CW'(cnt);
        bus.req[i]      = 1'b1;
    endtask

    // Time base: us every 10 cycles, ms every 1000, s effectively never here.
    initial begin
        forever begin
            @(posedge clk_main);
            #1;
            t_us = (cyc % 10 == 0);
            t_ms = (cyc % 1000 == 0) && (cyc > 0);
            t_s  = (cyc % 1000000 == 999999);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int t, t2, m;
    initial begin
        bus.req      = '0;
        bus.req_unit = '0;
        bus.req_cnt  = '0;

        goto(3);
        chk("rst_gnt",  32'(bus.gnt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_rem",  32'(bus.remaining), 0);
        rst_n = 1'b1;

        // Raw-cycle delay of 5
        t = 5;
        goto(t);
        set_req(0, 3, 5);
        push(0, 0, t + 1);
        push(1, 0, t + 6);
        goto(t + 1); chk("basic_rem_start", 32'(bus.remaining), 5);
        goto(t + 5); chk("basic_rem_last", 32'(bus.remaining), 1);
        goto(t + 6); chk("basic_rem_zero", 32'(bus.remaining), 0);
        chk("basic_busy_done", 32'(bus.busy), 1);
        goto(t + 7); bus.req[0] = 1'b0;
        chk("basic_busy_idle", 32'(bus.busy), 0);
        chk("basic_gnt_idle", 32'(bus.gnt), 0);

        rst_n = 1'b0;
        goto(t + 9);
        rst_n = 1'b1;

        // Round robin, all four requesters from ptr 0
        t = t + 10;
        goto(t);
        for (int i = 0; i < NR; i++) set_req(i, 3, 2);
        for (int k = 0; k < NR; k++) begin
            push(0, k, t + 1 + 4 * k);
            push(1, k, t + 3 + 4 * k);
        end
        for (int k = 0; k < NR; k++) begin
            goto(t + 4 + 4 * k);
            bus.req[k] = 1'b0;
        end
        t2 = t + 17;
        goto(t2);
        set_req(0, 3, 2);
        set_req(2, 3, 2);
        push(0, 0, t2 + 1); push(1, 0, t2 + 3);
        push(0, 2, t2 + 5); push(1, 2, t2 + 7);
        goto(t2 + 4); bus.req[0] = 1'b0;
        goto(t2 + 8); bus.req[2] = 1'b0;

        // Zero count in seconds: no wait for a tick
        t = t2 + 10;
        goto(t);
        set_req(1, 2, 0);
        push(0, 1, t + 1);
        push(1, 1, t + 1);
        goto(t + 1); chk("zero_busy", 32'(bus.busy), 1);
        chk("zero_rem", 32'(bus.remaining), 0);
        goto(t + 2); bus.req[1] = 1'b0;
        chk("zero_idle", 32'(bus.busy), 0);

        // Cancel at remaining 40, late unit/count edits ignored
        t = t + 5;
        goto(t);
        set_req(1, 3, 100);
        push(0, 1, t + 1);
        goto(t + 1); set_req(2, 3, 2);
        goto(t + 2); bus.req_cnt[1] = CW'(5); bus.req_unit[1] = 2'd0;
        goto(t + 61); chk("cancel_rem40", 32'(bus.remaining), 40);
        bus.req[1] = 1'b0;
        goto(t + 62); chk("cancel_rem0", 32'(bus.remaining), 0);
        chk("cancel_gnt", 32'(bus.gnt), 0);
        chk("cancel_busy", 32'(bus.busy), 0);
        push(0, 2, t + 63);
        push(1, 2, t + 65);
        goto(t + 63); chk("cancel_next_rem", 32'(bus.remaining), 2);
        goto(t + 66); bus.req[2] = 1'b0;

        // Reset mid-run at remaining 7, ptr must return to 0
        t = t + 70;
        goto(t);
        set_req(1, 3, 20);
        push(0, 1, t + 1);
        goto(t + 14); chk("rstrun_rem7", 32'(bus.remaining), 7);
        rst_n = 1'b0;
        bus.req[1] = 1'b0;
        goto(t + 15);
        chk("rstrun_gnt",  32'(bus.gnt), 0);
        chk("rstrun_done", 32'(bus.done), 0);
        chk("rstrun_busy", 32'(bus.busy), 0);
        chk("rstrun_rem",  32'(bus.remaining), 0);
        goto(t + 16); rst_n = 1'b1;
        goto(t + 17);
        set_req(0, 3, 1);
        set_req(2, 3, 1);
        push(0, 0, t + 18); push(1, 0, t + 19);
        push(0, 2, t + 21); push(1, 2, t + 22);
        goto(t + 20); bus.req[0] = 1'b0;
        goto(t + 23); bus.req[2] = 1'b0;

        // Millisecond delay of 3, request placed on a ms tick (not counted)
        m = ((cyc / 1000) + 1) * 1000;
        goto(m);
        set_req(0, 1, 3);
        push(0, 0, m + 1);
        push(1, 0, m + 3001);
        goto(m + 999);  chk("ms_rem3_us_ignored", 32'(bus.remaining), 3);
        goto(m + 1001); chk("ms_rem2", 32'(bus.remaining), 2);
        goto(m + 2001); chk("ms_rem1", 32'(bus.remaining), 1);
        goto(m + 3002); bus.req[0] = 1'b0;
        chk("ms_idle", 32'(bus.busy), 0);

        goto(cyc + 5);
        chk("events_outstanding", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
